// File: rtl/block_burst_responder_if.sv
// Request and word-burst signals between a cache-side block converter
// (master) and the memory-side block_burst_responder (slave).
interface block_burst_responder_if #(
    parameter int WSIZE      = 32,
    parameter int ADDR_WIDTH = 6
);
    // Request channel
    logic                  req_valid;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_accept;

    // Read burst: responder -> requester
    logic [WSIZE-1:0]      word_out;
    logic                  word_ready;
    logic                  word_out_hold;

    // Write burst: requester -> responder
    logic [WSIZE-1:0]      word_in;
    logic                  word_in_ready;
    logic                  pull_word;

    // End-of-burst pulse
    logic                  done;

    modport master (
        output req_valid, req_write, req_addr, word_out_hold, word_in, word_in_ready,
        input  req_accept, word_out, word_ready, pull_word, done
    );

    modport slave (
        input  req_valid, req_write, req_addr, word_out_hold, word_in, word_in_ready,
        output req_accept, word_out, word_ready, pull_word, done
    );
endinterface

// File: rtl/block_burst_responder.sv
// Memory-side responder: serves one block of BLOCK_WORDS words per request,
// reading from or writing to an internal block store. The store is split into
// one lane per word index so each lane is a plain single-port array.
module block_burst_responder #(
    parameter int WSIZE       = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_WIDTH  = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    block_burst_responder_if.slave  bus
);
    localparam int BEAT_W = $clog2(BLOCK_WORDS);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

    logic [1:0]            state_reg,      state_next;
    logic [BEAT_W-1:0]     beat_reg,       beat_next;
    logic [ADDR_WIDTH-1:0] addr_reg,       addr_next;
    logic [WSIZE-1:0]      word_out_reg,   word_out_next;
    logic                  word_ready_reg, word_ready_next;

    // Read port of the store: which block and which word lane feeds word_out
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [BEAT_W-1:0]     rd_beat;
    logic                  load_word;
    logic [WSIZE-1:0]      lane_rd [BLOCK_WORDS];

    // One storage lane per word index; a write beat lands in the lane
    // matching the current beat counter.
    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_lane
            logic [WSIZE-1:0] lane_mem [DEPTH];
            logic             lane_we;

            assign lane_we = (state_reg == ST_WRITE) && bus.word_in_ready &&
                             (beat_reg == BEAT_W'(gi));

            // Store the incoming word for this lane; contents are never reset
            always_ff @(posedge clock) begin
                if (lane_we) begin
                    lane_mem[addr_reg] <= bus.word_in;
                end
            end

            assign lane_rd[gi] = lane_mem[rd_addr];
        end
    endgenerate

    // Next-state, beat sequencing and read-data selection
    always_comb begin
        state_next      = state_reg;
        beat_next       = beat_reg;
        addr_next       = addr_reg;
        word_ready_next = word_ready_reg;
        load_word       = 1'b0;
        rd_addr         = addr_reg;
        rd_beat         = beat_reg + BEAT_W'(1);

        case (state_reg)
            ST_IDLE: begin
                // The first word is fetched straight from the request address
                // so it is already valid on the cycle after the accept edge.
                rd_addr = bus.req_addr;
                rd_beat = '0;
                if (bus.req_valid) begin
                    addr_next = bus.req_addr;
                    beat_next = '0;
                    if (bus.req_write) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next      = ST_READ;
                        load_word       = 1'b1;
                        word_ready_next = 1'b1;
                    end
                end
            end

            ST_READ: begin
                // A held beat leaves word_out, beat and word_ready untouched
                if (!bus.word_out_hold) begin
                    if (beat_reg == LAST_BEAT) begin
                        word_ready_next = 1'b0;
                        state_next      = ST_DONE;
                    end else begin
                        beat_next = beat_reg + BEAT_W'(1);
                        load_word = 1'b1;
                    end
                end
            end

            ST_WRITE: begin
                if (bus.word_in_ready) begin
                    beat_next = beat_reg + BEAT_W'(1);
                    if (beat_reg == LAST_BEAT) begin
                        state_next = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        word_out_next = load_word ? lane_rd[rd_beat] : word_out_reg;
    end

    // Control and output registers; reset drops any burst in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            beat_reg       <= '0;
            addr_reg       <= '0;
            word_out_reg   <= '0;
            word_ready_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            beat_reg       <= beat_next;
            addr_reg       <= addr_next;
            word_out_reg   <= word_out_next;
            word_ready_reg <= word_ready_next;
        end
    end

    assign bus.req_accept = (state_reg == ST_IDLE);
    assign bus.pull_word  = (state_reg == ST_WRITE);
    assign bus.done       = (state_reg == ST_DONE);
    assign bus.word_out   = word_out_reg;
    assign bus.word_ready = word_ready_reg;

endmodule

// File: tb/tb_block_burst_responder.sv
// Bench for block_burst_responder: directed bursts plus randomized traffic,
// checked against a word-array model of the block store.
module tb_block_burst_responder;
    localparam int WSIZE = 32;
    localparam int BW    = 4;
    localparam int AW    = 6;
    localparam int NBLK  = 2 ** AW;

    typedef logic [WSIZE-1:0] blk_t [BW];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    block_burst_responder_if #(.WSIZE(WSIZE), .ADDR_WIDTH(AW)) bus ();

    block_burst_responder #(
        .WSIZE      (WSIZE),
        .BLOCK_WORDS(BW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model of the store: what each block word should hold
    logic [WSIZE-1:0] ref_mem [NBLK][BW];
    bit               written [NBLK];
    blk_t             wblk;

    task automatic idle_inputs();
        bus.req_valid     = 1'b0;
        bus.req_write     = 1'b0;
        bus.req_addr      = '0;
        bus.word_out_hold = 1'b0;
        bus.word_in       = '0;
        bus.word_in_ready = 1'b0;
    endtask

    task automatic junk_request();
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = AW'($urandom);
    endtask

    // Write burst; rdy_mode 0 = word_in_ready held, 1 = toggling, 2 = random.
    // Called just after a falling edge with the responder idle.
    task automatic do_write(input logic [AW-1:0] addr, input blk_t words,
                            input int rdy_mode, input bit junk, input string name);
        int beat = 0;
        int cyc  = 0;
        bit rdy;
        checks++;
        if (bus.req_accept !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_before: req_accept=%b want 1", name, bus.req_accept);
        end
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = addr;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (beat < BW && cyc < 64) begin
            checks++;
            if (bus.pull_word !== 1'b1 || bus.req_accept !== 1'b0) begin
                errors++;
                $display("FAIL %s pull_word cycle %0d: pull_word=%b req_accept=%b want 1/0",
                         name, cyc, bus.pull_word, bus.req_accept);
            end
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.word_in_ready = rdy;
            bus.word_in       = rdy ? words[beat] : WSIZE'($urandom);
            if (junk) junk_request();
            @(posedge clk);
            if (rdy) begin
                ref_mem[addr][beat] = words[beat];
                beat++;
            end
            @(negedge clk);
            cyc++;
        end
        written[addr]     = 1'b1;
        bus.word_in_ready = 1'b0;
        bus.req_valid     = 1'b0;
        checks++;
        if (beat < BW) begin
            errors++;
            $display("FAIL %s timeout: beats=%0d want %0d", name, beat, BW);
        end
        if (rdy_mode == 0) begin
            checks++;
            if (cyc !== BW) begin
                errors++;
                $display("FAIL %s pull_cycles: got %0d want %0d", name, cyc, BW);
            end
        end
        checks++;
        if (bus.done !== 1'b1 || bus.pull_word !== 1'b0 || bus.req_accept !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: done=%b pull_word=%b req_accept=%b want 1/0/0",
                     name, bus.done, bus.pull_word, bus.req_accept);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.req_accept !== 1'b1) begin
            errors++;
            $display("FAIL %s back_to_idle: done=%b req_accept=%b want 0/1",
                     name, bus.done, bus.req_accept);
        end
        $display("write %s addr=%0d cycles=%0d", name, addr, cyc);
    endtask

    // Read burst; hold_mode 0 = no stall, 1 = 3-cycle stall on beat 2, 2 = random.
    task automatic do_read(input logic [AW-1:0] addr, input int hold_mode,
                           input bit junk, input string name);
        int beat  = 0;
        int cyc   = 0;
        int stall = 0;
        bit hold;
        checks++;
        if (bus.req_accept !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_before: req_accept=%b want 1", name, bus.req_accept);
        end
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = addr;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (beat < BW && cyc < 64) begin
            checks++;
            if (bus.word_ready !== 1'b1 || bus.word_out !== ref_mem[addr][beat]) begin
                errors++;
                $display("FAIL %s word beat %0d cycle %0d: word_ready=%b word_out=%h want 1/%h",
                         name, beat, cyc, bus.word_ready, bus.word_out, ref_mem[addr][beat]);
            end
            case (hold_mode)
                0:       hold = 1'b0;
                1:       hold = (beat == 2 && stall < 3);
                default: hold = 1'($urandom_range(0, 1));
            endcase
            if (hold) stall++;
            bus.word_out_hold = hold;
            if (junk) junk_request();
            @(posedge clk);
            if (!hold) beat++;
            @(negedge clk);
            cyc++;
        end
        bus.word_out_hold = 1'b0;
        bus.req_valid     = 1'b0;
        checks++;
        if (beat < BW || cyc !== BW + stall) begin
            errors++;
            $display("FAIL %s beat_count: beats=%0d cycles=%0d stalls=%0d want %0d beats",
                     name, beat, cyc, stall, BW);
        end
        if (hold_mode == 1) begin
            checks++;
            if (stall !== 3) begin
                errors++;
                $display("FAIL %s stall_count: got %0d want 3", name, stall);
            end
        end
        checks++;
        if (bus.word_ready !== 1'b0 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_pulse: word_ready=%b done=%b want 0/1",
                     name, bus.word_ready, bus.done);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.req_accept !== 1'b1) begin
            errors++;
            $display("FAIL %s back_to_idle: done=%b req_accept=%b want 0/1",
                     name, bus.done, bus.req_accept);
        end
        $display("read %s addr=%0d cycles=%0d stalls=%0d", name, addr, cyc, stall);
    endtask

    // Outputs must all be at their idle values
    task automatic check_idle_outputs(input string name);
        checks++;
        if (bus.req_accept !== 1'b1 || bus.word_ready !== 1'b0 || bus.pull_word !== 1'b0 ||
            bus.done !== 1'b0 || bus.word_out !== '0) begin
            errors++;
            $display("FAIL %s: accept=%b word_ready=%b pull_word=%b done=%b word_out=%h want 1/0/0/0/0",
                     name, bus.req_accept, bus.word_ready, bus.pull_word, bus.done, bus.word_out);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_release");
        $display("reset initial");
    endtask

    task automatic test_write_basic();
        wblk[0] = 32'h0000C0D1;
        wblk[1] = 32'h0000D0C1;
        wblk[2] = 32'h0000E0F1;
        wblk[3] = 32'h0000F0E1;
        do_write(6'd5, wblk, 0, 1'b0, "write_a5");
    endtask

    task automatic test_read_basic();
        do_read(6'd5, 0, 1'b0, "read_a5");
    endtask

    task automatic test_read_stall();
        do_read(6'd5, 1, 1'b0, "read_a5_stall");
    endtask

    task automatic test_write_toggle();
        for (int i = 0; i < BW; i++) wblk[i] = WSIZE'(i + 1);
        do_write(6'd9, wblk, 1, 1'b1, "write_a9_toggle");
        do_read(6'd9, 0, 1'b1, "read_a9");
        do_read(6'd5, 0, 1'b0, "read_a5_untouched");
    endtask

    // Asynchronous reset two beats into a read, then a clean re-read
    task automatic test_reset_mid_read();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 6'd5;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.word_out !== ref_mem[5][2]) begin
            errors++;
            $display("FAIL reset_read_pre: word_out=%h want %h", bus.word_out, ref_mem[5][2]);
        end
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("reset_async_read");
        @(negedge clk);
        check_idle_outputs("reset_read_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_read_no_done");
        $display("reset mid-read addr=5");
        do_read(6'd5, 0, 1'b0, "read_a5_after_reset");
    endtask

    // Asynchronous reset two beats into a write: first words new, rest old
    task automatic test_reset_mid_write();
        for (int i = 0; i < BW; i++) wblk[i] = 32'hAA00_0000 | WSIZE'(i);
        do_write(6'd12, wblk, 0, 1'b0, "write_a12_old");
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 6'd12;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus.word_in_ready = 1'b1;
            bus.word_in       = 32'h5500_0000 | WSIZE'(b);
            if (b < 2) begin
                @(posedge clk);
                ref_mem[12][b] = 32'h5500_0000 | WSIZE'(b);
                @(negedge clk);
            end
        end
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("reset_async_write");
        @(negedge clk);
        rst_n = 1'b1;
        bus.word_in_ready = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_write_no_done");
        $display("reset mid-write addr=12");
        do_read(6'd12, 0, 1'b0, "read_a12_partial");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < BW; i++) wblk[i] = WSIZE'($urandom);
        do_write(6'd20, wblk, 0, 1'b0, "b2b_write_a20");
        do_read(6'd20, 0, 1'b0, "b2b_read_a20");
        for (int i = 0; i < BW; i++) wblk[i] = WSIZE'($urandom);
        do_write(6'd20, wblk, 0, 1'b0, "b2b_rewrite_a20");
        do_read(6'd20, 0, 1'b0, "b2b_reread_a20");
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int n = 0; n < 30; n++) begin
            a = AW'($urandom_range(0, NBLK - 1));
            if (written[a] && $urandom_range(0, 1) == 1) begin
                do_read(a, 2, 1'($urandom_range(0, 1)), "rand_read");
            end else begin
                for (int i = 0; i < BW; i++) wblk[i] = WSIZE'($urandom);
                do_write(a, wblk, 2, 1'($urandom_range(0, 1)), "rand_write");
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_read_stall();
        test_write_toggle();
        test_reset_mid_read();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound the whole run in case the responder wedges
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
